// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control
// Desc   : RV32I multicycle main control FSM driving ALU selects/op and
//          datapath strobes. Optional macro MULTICYCLE_TRAP_EN adds a sticky
//          TRAP state for illegal instructions.
// Rev    : 1.0
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       IR_write,
  output logic       PC_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [1:0] ALU_src1_sel,
  output logic [1:0] ALU_src2_sel,
  output logic [3:0] ALU_ctrl,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
`ifdef MULTICYCLE_TRAP_EN
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
`else
    S_LUI      = 4'd13
`endif
  } state_t;

`ifdef MULTICYCLE_TRAP_EN
  localparam state_t S_ILLEGAL = S_TRAP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic       w_mem_req, w_mem_write, w_ir_write, w_pc_write, w_reg_write;
  logic [3:0] w_alu_op;
`ifdef MULTICYCLE_TRAP_EN
  logic       w_illegal;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // SUB only for R-type; funct7b5 picks SRA for both R and I shifts
  always_comb begin
    w_alu_op = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    imm_src = 3'd0;
    case (opcode)
      OP_STORE:         imm_src = 3'd1;
      OP_BRANCH:        imm_src = 3'd2;
      OP_JAL:           imm_src = 3'd3;
      OP_LUI, OP_AUIPC: imm_src = 3'd4;
      default:          imm_src = 3'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'd0;
    ALU_src1_sel = 2'd0;
    ALU_src2_sel = 2'd0;
    ALU_ctrl     = ALU_ADD;
`ifdef MULTICYCLE_TRAP_EN
    w_illegal    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        ALU_src2_sel = 2'd2;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          result_src = 2'd2;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd1;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        state_d      = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'd1;
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALU_src1_sel = 2'd2;
        ALU_ctrl     = w_alu_op;
        state_d      = S_ALUWB;
      end
      S_EXECI: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        ALU_ctrl     = w_alu_op;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src1_sel = 2'd2;
        ALU_ctrl     = ALU_SUB;
        state_d      = S_FETCH;
        if (funct3 == 3'b000)      w_pc_write = zero;
        else if (funct3 == 3'b001) w_pc_write = ~zero;
        else                       state_d    = S_ILLEGAL;
      end
      S_JAL: begin
        w_pc_write   = 1'b1;
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd2;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        result_src   = 2'd2;
        w_pc_write   = 1'b1;
        state_d      = S_LINK;
      end
      S_LINK: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd2;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        result_src  = 2'd3;
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MULTICYCLE_TRAP_EN
      S_TRAP: begin
        w_illegal = 1'b1;
        state_d   = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset must suppress strobes combinationally, since FETCH itself requests memory
  assign mem_req   = w_mem_req   & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign IR_write  = w_ir_write  & ~reset;
  assign PC_write  = w_pc_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
`ifdef MULTICYCLE_TRAP_EN
  assign illegal_instr = w_illegal & ~reset;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire
